bus_memory_responder: RTL
=========================

# bus_memory_responder

On-chip bus responder (slave) that backs a word-addressed memory window and answers single and burst read/write transactions issued by bus initiators such as the CPU memory stage. It decodes the multiplexed address phase and serves read bursts with a configurable initial latency, honouring initiator back-pressure. It absorbs write bursts with byte enables and signals protocol violations on the bus error line. All bus outputs are zero when the block is not driving, so they can be wired-OR onto the shared bus.

## Interface
- BASE_ADDRESS, 32'h5000_0000: window base, aligned to window size.
- ADDRESS_BITS, 10: word-address width; window = 4·2^ADDRESS_BITS bytes.
- READ_LATENCY, 2: wait cycles between address sample and first read word (0..15).
- WRITE_LATENCY, 1: cycles busyOut is held after a write address phase (0..15).
- clock  in  1  single system clock; all logic is on posedge.
- reset  in  1  synchronous, active-high.
- beginTransactionIn  in  1  address phase strobe.
- addressDataIn  in  32  address during begin; write data otherwise.
- readNotWriteIn  in  1  1 = read, sampled with begin.
- byteEnablesIn  in  4  write byte lanes, sampled with begin; applied to all words.
- burstSizeIn  in  8  burst length minus 1, sampled with begin.
- dataValidIn  in  1  write word present on addressDataIn.
- endTransactionIn  in  1  initiator ends a write or aborts a read.
- busyIn  in  1  initiator cannot accept the current read word.
- addressDataOut  out  32  read data; 0 when not valid.
- dataValidOut  out  1  read word valid.
- endTransactionOut  out  1  one-cycle pulse after the last read word.
- busyOut  out  1  responder not accepting write data.
- busErrorOut  out  1  one-cycle error pulse.

## Operation
- Hit: beginTransactionIn=1 and addressDataIn[31:ADDRESS_BITS+2] == BASE_ADDRESS[31:ADDRESS_BITS+2]. Misses are ignored; no output changes.
- Latched on hit: word address = addressDataIn[ADDRESS_BITS+1:2], rnw, byte enables, remaining = burstSizeIn+1 (9-bit).
- States:
  - IDLE: wait for a hit.
  - READ_WAIT: count READ_LATENCY cycles, then go to READ_DATA.
  - READ_DATA: present mem[addr]. When busyIn=0, the word is consumed: addr+1, remaining−1. When the last word is consumed, go to READ_END.
  - READ_END: pulse endTransactionOut, then go to IDLE.
  - WRITE_WAIT: busyOut=1 for WRITE_LATENCY cycles, then go to WRITE.
  - WRITE: each dataValidIn=1 writes the enabled lanes of addressDataIn to mem[addr], then addr+1, remaining−1. endTransactionIn=1 goes to IDLE.
- Address increment wraps modulo 2^ADDRESS_BITS within the window.
- While busyIn=1, the read word and dataValidOut are held unchanged.
- Write word beyond the burst length (remaining=0): not written; busErrorOut pulses next cycle.
- endTransactionIn with fewer words than the burst length: accepted silently.
- endTransactionIn during READ_WAIT or READ_DATA is an abort: go to IDLE next cycle, no endTransactionOut.
- dataValidIn and endTransactionIn in the same cycle: the word is written first, then go to IDLE.
- beginTransactionIn while not IDLE: ignored; busErrorOut pulses.
- byteEnablesIn=0000 on a write: words are counted but memory is unchanged.

## Timing
- Reset: state IDLE; all outputs 0. Memory contents are not reset.
- Reset mid-transaction: outputs are 0 the cycle after reset is sampled. A write in flight in the reset cycle is not performed.
- Begin sampled at edge T:
  - First read word valid from cycle T+1+READ_LATENCY.
  - One word per cycle while busyIn=0.
  - endTransactionOut in the cycle after the last word is consumed.
- Write: busyOut high during cycles T+1..T+WRITE_LATENCY. dataValidIn is ignored while busyOut=1. With WRITE_LATENCY=0, data is accepted from T+1.
- Memory read is synchronous: the read address register is updated on consume so the next word is ready in the next cycle, sustaining 1 word/cycle.
- busErrorOut is registered, one cycle wide, one cycle after the offending event.

## Test plan
- Single read: preload mem[3]=32'hDEADBEEF; begin addr 32'h5000_000C, rnw=1, burst 0 → dataValidOut at T+3 with 32'hDEADBEEF; endTransactionOut at T+4; outputs 0 at T+5.
- Read burst with back-pressure: burst 3 at word 1022; busyIn high on the 2nd word for 2 cycles → words 1022, 1023, 0, 1 in order; 2nd word held 3 cycles; one endTransactionOut.
- Byte-enable write burst: begin addr 32'h5000_0010, be=4'b0101, burst 1; data 32'h11223344, then 32'hAABBCCDD; endTransactionIn → mem[4]=32'h00220044 and mem[5]=32'h00BB00DD from zero init; busyOut high at T+1 only.
- Overrun: burst 0, two dataValidIn words → only the first is written; busErrorOut pulses once, one cycle after the second word.
- Miss, abort, and mid-burst reset: a begin at 32'h6000_0000 leaves all outputs 0. A read burst 7 with endTransactionIn after 2 words → IDLE, no endTransactionOut. reset mid-burst → all outputs 0 next cycle; a later read returns preserved data.
- Begin while busy: a second begin during READ_WAIT → busErrorOut pulse; the original burst completes unaffected.

Source files
------------

// File: rtl/bus_memory_responder.sv
// Bus responder backing a word-addressed memory window. It serves single and
// burst reads with a programmable initial latency and initiator back-pressure,
// absorbs byte-enabled write bursts, and reports protocol violations on a
// one-cycle error pulse. All outputs are zero while idle so they can be
// wire-ORed onto a shared bus.
module bus_memory_responder #(
  parameter logic [31:0] BASE_ADDRESS  = 32'h5000_0000,
  parameter int unsigned ADDRESS_BITS  = 10,
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned WRITE_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        beginTransactionIn,
  input  logic [31:0] addressDataIn,
  input  logic        readNotWriteIn,
  input  logic [3:0]  byteEnablesIn,
  input  logic [7:0]  burstSizeIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
  input  logic        busyIn,
  output logic [31:0] addressDataOut,
  output logic        dataValidOut,
  output logic        endTransactionOut,
  output logic        busyOut,
  output logic        busErrorOut
);

  localparam int unsigned AW    = ADDRESS_BITS;
  localparam int unsigned DEPTH = 2 ** ADDRESS_BITS;
  // Last value of the wait counter before leaving the wait state.
  localparam logic [3:0] RL_LAST = 4'((READ_LATENCY  == 0) ? 0 : READ_LATENCY  - 1);
  localparam logic [3:0] WL_LAST = 4'((WRITE_LATENCY == 0) ? 0 : WRITE_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ_WAIT, S_READ_DATA, S_READ_END, S_WRITE_WAIT, S_WRITE
  } state_t;

  state_t        r_state, w_next_state;
  logic [AW-1:0] r_addr, w_next_addr;
  logic [8:0]    r_remaining, w_next_remaining;
  logic [3:0]    r_be, w_next_be;
  logic [3:0]    r_cnt, w_next_cnt;
  logic          r_bus_err, w_bus_err;
  logic          w_hit;
  logic          w_rd_load;
  logic [AW-1:0] w_rd_addr;
  logic          w_mem_we;
  logic [31:0]   r_rdata;
  logic [31:0]   r_mem [DEPTH];

  assign w_hit = beginTransactionIn &&
                 (addressDataIn[31:AW+2] == BASE_ADDRESS[31:AW+2]);

  // Next-state, address/count updates, memory strobes and error detection.
  always_comb begin
    w_next_state     = r_state;
    w_next_addr      = r_addr;
    w_next_remaining = r_remaining;
    w_next_be        = r_be;
    w_next_cnt       = r_cnt;
    w_rd_load        = 1'b0;
    w_rd_addr        = r_addr;
    w_mem_we         = 1'b0;
    w_bus_err        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_hit) begin
          w_next_addr      = addressDataIn[AW+1:2];
          w_next_remaining = {1'b0, burstSizeIn} + 9'd1;
          w_next_be        = byteEnablesIn;
          w_next_cnt       = '0;
          if (readNotWriteIn) begin
            // Zero latency fetches the first word straight from the address phase.
            if (READ_LATENCY == 0) begin
              w_rd_load    = 1'b1;
              w_rd_addr    = addressDataIn[AW+1:2];
              w_next_state = S_READ_DATA;
            end else begin
              w_next_state = S_READ_WAIT;
            end
          end else begin
            w_next_state = (WRITE_LATENCY == 0) ? S_WRITE : S_WRITE_WAIT;
          end
        end
      end
      S_READ_WAIT: begin
        if (endTransactionIn) begin
          w_next_state = S_IDLE;
        end else if (r_cnt == RL_LAST) begin
          w_rd_load    = 1'b1;
          w_next_state = S_READ_DATA;
        end else begin
          w_next_cnt = r_cnt + 4'd1;
        end
      end
      S_READ_DATA: begin
        if (endTransactionIn) begin
          w_next_state = S_IDLE;
        end else if (!busyIn) begin
          if (r_remaining == 9'd1) begin
            w_next_remaining = '0;
            w_next_state     = S_READ_END;
          end else begin
            // Prefetch the following word so one word per cycle is sustained.
            w_next_addr      = r_addr + AW'(1);
            w_next_remaining = r_remaining - 9'd1;
            w_rd_load        = 1'b1;
            w_rd_addr        = r_addr + AW'(1);
          end
        end
      end
      S_READ_END: w_next_state = S_IDLE;
      S_WRITE_WAIT: begin
        if (r_cnt == WL_LAST) w_next_state = S_WRITE;
        else                  w_next_cnt   = r_cnt + 4'd1;
      end
      S_WRITE: begin
        if (dataValidIn) begin
          if (r_remaining != '0) begin
            w_mem_we         = 1'b1;
            w_next_addr      = r_addr + AW'(1);
            w_next_remaining = r_remaining - 9'd1;
          end else begin
            w_bus_err = 1'b1;
          end
        end
        if (endTransactionIn) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
    if (beginTransactionIn && (r_state != S_IDLE)) w_bus_err = 1'b1;
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_be        <= '0;
      r_cnt       <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_addr      <= w_next_addr;
      r_remaining <= w_next_remaining;
      r_be        <= w_next_be;
      r_cnt       <= w_next_cnt;
      r_bus_err   <= w_bus_err;
    end
  end

  // Memory array: byte-lane writes (suppressed during reset) and registered read.
  always_ff @(posedge clock) begin
    if (w_mem_we && !reset) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (r_be[b]) r_mem[r_addr][8*b +: 8] <= addressDataIn[8*b +: 8];
      end
    end
    if (w_rd_load) r_rdata <= r_mem[w_rd_addr];
  end

  assign dataValidOut      = (r_state == S_READ_DATA);
  assign addressDataOut    = dataValidOut ? r_rdata : '0;
  assign endTransactionOut = (r_state == S_READ_END);
  assign busyOut           = (r_state == S_WRITE_WAIT);
  assign busErrorOut       = r_bus_err;

endmodule
